// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots, fetches sequentially, takes redirects with a one-cycle bubble, and halts.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned redirect targets trap to TRAP_VECTOR and pulse misalign.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_ready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic [31:0] pc_out,
    output logic        fetch_valid,
    output logic [31:0] fetch_count,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_REDIRECT,
        ST_HALT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_count;
    logic [31:0] w_count_next;
    logic        w_fetch_valid;
    logic        w_accept;
    logic        w_redirect_take;
    logic [31:0] w_redirect_pc;
    logic        w_target_misaligned;

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_unused_cfg;

    assign w_target_misaligned = |redirect_target[1:0];
    assign w_redirect_pc       = w_target_misaligned ? TRAP_VECTOR : redirect_target;
    assign w_unused_cfg        = 1'b0;
`else
    logic w_unused_cfg;

    // Low target bits are dropped, so the trap vector has no use in this build.
    assign w_target_misaligned = 1'b0;
    assign w_redirect_pc       = {redirect_target[31:2], 2'b00};
    assign w_unused_cfg        = ^{redirect_target[1:0], TRAP_VECTOR};
`endif

    // Redirect outranks halt, halt outranks stall, stall outranks a fetch accept.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_count_next    = r_count;
        w_redirect_take = 1'b0;
        w_accept        = 1'b0;
        w_fetch_valid   = (r_state == ST_RUN);

        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    w_redirect_take = 1'b1;
                end else if (halt) begin
                    w_state_next = ST_HALT;
                end else if (fetch_ready && !stall) begin
                    w_accept = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (redirect_valid) begin
                    w_redirect_take = 1'b1;
                end else if (halt) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    w_redirect_take = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase

        if (w_redirect_take) begin
            w_state_next = ST_REDIRECT;
            w_pc_next    = w_redirect_pc;
        end else if (w_accept) begin
            w_pc_next    = r_pc + 32'd4;
            w_count_next = r_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_count <= w_count_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Pulse lines up with the cycle pc_out first shows TRAP_VECTOR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redirect_take && w_target_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    assign misalign = w_target_misaligned;
`endif

    assign pc_out      = r_pc;
    assign fetch_count = r_count;
    assign fetch_valid = w_fetch_valid;

endmodule
